// File: rtl/gbt_frame_checker.sv
// GBT RX link verifier: checks 80-bit frames against the far-end counter pattern,
// acquires lock, and reports frame/error counts and link state.

package gbt_frame_checker_pkg;
    typedef struct packed {
        logic clk;
        logic reset;
    } ckrs_t;
endpackage

module gbt_frame_checker
    import gbt_frame_checker_pkg::*;
#(
    parameter int LOCK_COUNT    = 16,
    parameter int UNLOCK_ERRORS = 4
) (
    input  ckrs_t       ClkRs_ix,
    input  logic        rx_ready_i,
    input  logic        rx_valid_i,
    input  logic [79:0] rx_data_ib80,
    input  logic        clear_counters_i,
    output logic        link_locked_o,
    output logic [1:0]  state_ob2,
    output logic        error_o,
    output logic [31:0] frame_cnt_ob32,
    output logic [31:0] error_cnt_ob32
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        LOCKED = 2'd2
    } state_t;

    localparam logic [7:0] LOCK_CNT_C   = 8'(LOCK_COUNT);
    localparam logic [7:0] UNLOCK_CNT_C = 8'(UNLOCK_ERRORS);

    logic clk;
    logic rst_n;
    assign clk   = ClkRs_ix.clk;
    assign rst_n = ClkRs_ix.reset;

    state_t      state_q, state_d;
    logic [15:0] expected_q, expected_d;
    logic [7:0]  good_cnt_q, good_cnt_d;
    logic [7:0]  bad_cnt_q, bad_cnt_d;
    logic [31:0] frame_cnt_q, frame_cnt_d;
    logic [31:0] error_cnt_q, error_cnt_d;
    logic        error_q, error_d;

    logic [15:0] seq;
    logic        consistent;
    logic        good_frame;
    logic        frame_inc;
    logic        error_inc;
    logic [7:0]  good_next;
    logic [7:0]  bad_next;

    assign seq        = rx_data_ib80[15:0];
    assign consistent = (rx_data_ib80[31:16] == seq) && (rx_data_ib80[47:32] == seq) &&
                        (rx_data_ib80[63:48] == seq) && (rx_data_ib80[79:64] == seq);
    assign good_frame = consistent && (seq == expected_q);

    always_comb begin
        // NOTE: every signal written here gets a default first so no latch is inferred.
        state_d    = state_q;
        expected_d = expected_q;
        good_cnt_d = good_cnt_q;
        bad_cnt_d  = bad_cnt_q;
        error_d    = 1'b0;
        frame_inc  = 1'b0;
        error_inc  = 1'b0;
        good_next  = good_cnt_q;
        bad_next   = bad_cnt_q;

        if (!rx_ready_i) begin
            state_d    = IDLE;
            good_cnt_d = '0;
            bad_cnt_d  = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    good_cnt_d = '0;
                    bad_cnt_d  = '0;
                    state_d    = SEARCH;
                end
                SEARCH: begin
                    if (rx_valid_i) begin
                        if (!consistent) begin
                            good_cnt_d = '0;
                        end else begin
                            // A mismatching but self-consistent frame restarts the run from its seq.
                            if (good_cnt_q == '0 || seq != expected_q) begin
                                good_next  = 8'd1;
                                expected_d = seq + 16'd1;
                            end else begin
                                good_next  = good_cnt_q + 8'd1;
                                expected_d = expected_q + 16'd1;
                            end
                            good_cnt_d = good_next;
                            if (good_next == LOCK_CNT_C) begin
                                state_d   = LOCKED;
                                bad_cnt_d = '0;
                            end
                        end
                    end
                end
                LOCKED: begin
                    if (rx_valid_i) begin
                        frame_inc  = 1'b1;
                        expected_d = expected_q + 16'd1;
                        if (good_frame) begin
                            bad_cnt_d = '0;
                        end else begin
                            error_inc = 1'b1;
                            error_d   = 1'b1;
                            bad_next  = bad_cnt_q + 8'd1;
                            bad_cnt_d = bad_next;
                            if (bad_next == UNLOCK_CNT_C) begin
                                state_d    = SEARCH;
                                good_cnt_d = '0;
                                bad_cnt_d  = '0;
                            end
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        frame_cnt_d = frame_cnt_q;
        error_cnt_d = error_cnt_q;
        if (clear_counters_i) begin
            frame_cnt_d = '0;
            error_cnt_d = '0;
        end else begin
            if (frame_inc && frame_cnt_q != 32'hFFFF_FFFF) frame_cnt_d = frame_cnt_q + 32'd1;
            if (error_inc && error_cnt_q != 32'hFFFF_FFFF) error_cnt_d = error_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (!rst_n) begin
            state_q     <= IDLE;
            expected_q  <= '0;
            good_cnt_q  <= '0;
            bad_cnt_q   <= '0;
            frame_cnt_q <= '0;
            error_cnt_q <= '0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            expected_q  <= expected_d;
            good_cnt_q  <= good_cnt_d;
            bad_cnt_q   <= bad_cnt_d;
            frame_cnt_q <= frame_cnt_d;
            error_cnt_q <= error_cnt_d;
            error_q     <= error_d;
        end
    end

    assign link_locked_o  = (state_q == LOCKED);
    assign state_ob2      = state_q;
    assign error_o        = error_q;
    assign frame_cnt_ob32 = frame_cnt_q;
    assign error_cnt_ob32 = error_cnt_q;

endmodule

// File: tb/tb_gbt_frame_checker.sv
// Directed, table-driven bench for gbt_frame_checker with a few hand-written sequences.

module tb_gbt_frame_checker;
    import gbt_frame_checker_pkg::*;

    typedef struct {
        logic        ready;
        logic        valid;
        logic [79:0] data;
        logic        clear;
        logic [1:0]  st;
        logic        err;
        logic [31:0] fc;
        logic [31:0] ec;
    } vec_t;

    logic        clk;
    logic        rst_n;
    ckrs_t       clk_rs;
    logic        rx_ready;
    logic        rx_valid;
    logic [79:0] rx_data;
    logic        clear_cnt;
    logic        link_locked;
    logic [1:0]  state;
    logic        error;
    logic [31:0] frame_cnt;
    logic [31:0] error_cnt;

    int checks = 0;
    int errors = 0;
    vec_t vecs[$];

    assign clk_rs.clk   = clk;
    assign clk_rs.reset = rst_n;

    gbt_frame_checker #(.LOCK_COUNT(16), .UNLOCK_ERRORS(4)) dut (
        .ClkRs_ix         (clk_rs),
        .rx_ready_i       (rx_ready),
        .rx_valid_i       (rx_valid),
        .rx_data_ib80     (rx_data),
        .clear_counters_i (clear_cnt),
        .link_locked_o    (link_locked),
        .state_ob2        (state),
        .error_o          (error),
        .frame_cnt_ob32   (frame_cnt),
        .error_cnt_ob32   (error_cnt)
    );

    initial clk = 1'b0;
    always #12 clk = ~clk;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    function automatic logic [79:0] fr(input logic [15:0] s);
        return {5{s}};
    endfunction

    function automatic logic [79:0] fr_lane(input logic [15:0] s, input int lane, input logic [15:0] v);
        logic [79:0] d;
        d = {5{s}};
        d[lane*16 +: 16] = v;
        return d;
    endfunction

    task automatic add(input logic r, input logic v, input logic [79:0] d, input logic c,
                       input logic [1:0] st, input logic e, input logic [31:0] fc, input logic [31:0] ec);
        vec_t x;
        x.ready = r; x.valid = v; x.data = d; x.clear = c;
        x.st = st; x.err = e; x.fc = fc; x.ec = ec;
        vecs.push_back(x);
    endtask

    task automatic check_outputs(input string tag, input logic [1:0] st, input logic e,
                                 input logic [31:0] fc, input logic [31:0] ec);
        check({tag, " state"}, 32'(state), 32'(st));
        check({tag, " locked"}, 32'(link_locked), 32'(st == 2'd2));
        check({tag, " error"}, 32'(error), 32'(e));
        check({tag, " frame_cnt"}, frame_cnt, fc);
        check({tag, " error_cnt"}, error_cnt, ec);
    endtask

    initial begin
        int n;

        // Lock acquisition from seq 0
        add(1, 0, '0, 0, 1, 0, 0, 0);
        for (int i = 0; i < 15; i++) add(1, 1, fr(16'(i)), 0, 1, 0, 0, 0);
        add(1, 1, fr(16'h000F), 0, 2, 0, 0, 0);
        add(1, 1, fr(16'h0010), 0, 2, 0, 1, 0);
        // Single corrupted lane, then pattern resumes
        add(1, 1, fr_lane(16'h0011, 3, 16'hDEAD), 0, 2, 1, 2, 1);
        add(1, 1, fr(16'h0012), 0, 2, 0, 3, 1);
        // Clear, then four wrong-seq frames force SEARCH
        add(1, 0, '0, 1, 2, 0, 0, 0);
        add(1, 1, fr(16'h0100), 0, 2, 1, 1, 1);
        add(1, 1, fr(16'h0100), 0, 2, 1, 2, 2);
        add(1, 1, fr(16'h0100), 0, 2, 1, 3, 3);
        add(1, 1, fr(16'h0100), 0, 1, 1, 4, 4);
        // Relock after 16 good frames; counters held
        for (int i = 0; i < 15; i++) add(1, 1, fr(16'h0200 + 16'(i)), 0, 1, 0, 4, 4);
        add(1, 1, fr(16'h020F), 0, 2, 0, 4, 4);
        // rx_ready drop: valid frame in same cycle ignored
        add(0, 1, fr(16'h0210), 0, 0, 0, 4, 4);
        add(1, 0, '0, 0, 1, 0, 4, 4);
        // Inconsistent frame, seed, reseed, then lock across the 0xFFFF wrap
        add(1, 1, fr(16'h0500), 0, 1, 0, 4, 4);
        add(1, 1, fr_lane(16'h0501, 2, 16'h0777), 0, 1, 0, 4, 4);
        add(1, 1, fr(16'h0600), 0, 1, 0, 4, 4);
        add(1, 1, fr(16'hFFF8), 0, 1, 0, 4, 4);
        for (int i = 1; i < 15; i++) add(1, 1, fr(16'hFFF8 + 16'(i)), 0, 1, 0, 4, 4);
        add(1, 1, fr(16'h0007), 0, 2, 0, 4, 4);
        add(1, 0, fr(16'h9999), 0, 2, 0, 4, 4);
        add(1, 1, fr(16'h0008), 0, 2, 0, 5, 4);
        // Clear wins over a same-cycle bad frame; error_o still pulses
        add(1, 1, fr(16'h1234), 1, 2, 1, 0, 0);
        add(1, 1, fr(16'h000A), 0, 2, 0, 1, 0);

        rst_n = 1'b0; rx_ready = 1'b0; rx_valid = 1'b0; rx_data = '0; clear_cnt = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check_outputs("reset", 2'd0, 1'b0, 32'd0, 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            rx_ready  = vecs[i].ready;
            rx_valid  = vecs[i].valid;
            rx_data   = vecs[i].data;
            clear_cnt = vecs[i].clear;
            @(posedge clk);
            @(negedge clk);
            check_outputs($sformatf("v%0d", i), vecs[i].st, vecs[i].err, vecs[i].fc, vecs[i].ec);
        end

        // Reset while locked with a frame present
        rst_n = 1'b0; rx_ready = 1'b1; rx_valid = 1'b1; rx_data = fr(16'h000B); clear_cnt = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_outputs("midreset", 2'd0, 1'b0, 32'd0, 32'd0);

        // Lock latency with back-to-back frames, bounded wait
        rst_n = 1'b1; rx_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("relock search", 32'(state), 32'd1);
        n = 0;
        while (!link_locked && n < 40) begin
            rx_valid = 1'b1;
            rx_data  = fr(16'h3000 + 16'(n));
            @(posedge clk);
            @(negedge clk);
            n++;
        end
        check("lock frames", 32'(n), 32'd16);
        check("lock reached", 32'(link_locked), 32'd1);
        rx_valid = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
